// File: rtl/iir_pkg.sv
// Shared widths, state type and packing helper for the IIR output stage.
package iir_pkg;

    localparam int SAMPLE_W = 16;
    localparam int WORD_W   = 32;
    localparam int WADDR_W  = 19;

    typedef enum logic [1:0] {RUN, FLUSH, DRAIN, DONE} pk_state_t;

    function automatic logic [WORD_W-1:0] pack_pair(input logic [SAMPLE_W-1:0] hi,
                                                    input logic [SAMPLE_W-1:0] lo);
        return {hi, lo};
    endfunction

endpackage

// File: rtl/iir_out_packer_if.sv
// Sample input and packed-word output port of the IIR output packer.
interface iir_out_packer_if;
    import iir_pkg::*;

    logic                in_valid;
    logic [SAMPLE_W-1:0] in_data;
    logic                in_last;
    logic                out_valid;
    logic                out_ready;
    logic [WORD_W-1:0]   out_data;
    logic [WADDR_W-1:0]  out_addr;
    logic                done;
    logic                overflow;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  out_valid, out_data, out_addr, done, overflow
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output out_valid, out_data, out_addr, done, overflow
    );

endinterface

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO; pointers carry an extra wrap bit for full/empty.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    // When full, a same-cycle pop frees the slot being written, so both proceed.
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr[AW-1:0]] <= din;
                wr_ptr              <= wr_ptr + (AW+1)'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/iir_out_packer.sv
// Packs 16-bit filter samples into 32-bit words, buffers them and flushes
// the stream with a single done pulse once the buffer drains.
module iir_out_packer
    import iir_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    iir_out_packer_if.slave bus
);

    pk_state_t           state;
    pk_state_t           state_nxt;
    logic                half_valid;
    logic [SAMPLE_W-1:0] half_data;
    logic                push;
    logic [WORD_W-1:0]   push_word;
    logic                pop;
    logic                fifo_empty;
    logic                fifo_full;
    logic [WORD_W-1:0]   head;
    logic [WADDR_W-1:0]  addr;
    logic                overflow_q;
    logic                done_c;

    sync_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (push_word),
        .pop   (pop),
        .dout  (head),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    assign pop           = !fifo_empty && bus.out_ready;
    assign bus.out_valid = !fifo_empty;
    assign bus.out_data  = head;
    assign bus.out_addr  = addr;
    assign bus.done      = done_c;
    assign bus.overflow  = overflow_q;

    always_comb begin
        state_nxt = state;
        push      = 1'b0;
        push_word = '0;
        done_c    = 1'b0;
        case (state)
            RUN: begin
                if (bus.in_valid && half_valid) begin
                    push      = 1'b1;
                    push_word = pack_pair(bus.in_data, half_data);
                end
                if (bus.in_last) begin
                    state_nxt = FLUSH;
                end
            end
            FLUSH: begin
                if (half_valid) begin
                    push      = 1'b1;
                    push_word = pack_pair('0, half_data);
                end
                state_nxt = DRAIN;
            end
            DRAIN: begin
                if (fifo_empty) begin
                    done_c    = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = DONE;
            end
            default: begin
                state_nxt = RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= RUN;
            half_valid <= 1'b0;
            half_data  <= '0;
            addr       <= '0;
            overflow_q <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == RUN && bus.in_valid) begin
                half_valid <= !half_valid;
                if (!half_valid) begin
                    half_data <= bus.in_data;
                end
            end else if (state == FLUSH) begin
                half_valid <= 1'b0;
            end
            if (pop) begin
                addr <= addr + WADDR_W'(1);
            end
            if (push && fifo_full && !pop) begin
                overflow_q <= 1'b1;
            end
        end
    end

endmodule
